// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that shares one 8x8 unsigned shift-add multiplier among NREQ requesters.
// Define MUL_ARB_TIMEOUT_EN to add a BUSY-cycle watchdog that answers with rsp_err after TIMEOUT cycles.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       rsp_product,
    output logic              rsp_err,
    output logic              busy,
    output logic              mul_start,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic              mul_ready,
    input  logic [15:0]       mul_product
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("mul_arbiter: NREQ must be 2..8 and TIMEOUT must be at least 1");
    end

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [15:0]   prod_q, prod_d;

    logic [PW-1:0] winner;
    logic          win_found;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          err_q, err_d;

    assign cnt_inc = cnt_q + CW'(1);
`endif

    // Round-robin search starts just past the last winner and wraps, so the last winner ranks lowest.
    // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        winner    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req[PW'(idx)]) begin
                win_found = 1'b1;
                winner    = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    a_d     = req_a[{winner, 3'b000} +: 8];
                    b_d     = req_b[{winner, 3'b000} +: 8];
                    ptr_d   = winner;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_BUSY;
`ifdef MUL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            // mul_ready is only trusted here: before our start pulse it may be stale from an older operation.
            S_BUSY: begin
                if (mul_ready) begin
                    prod_d  = mul_product;
                    state_d = S_DONE;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
`ifdef MUL_ARB_TIMEOUT_EN
                else if (cnt_inc == CW'(TIMEOUT)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_inc;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Grant is combinational so the requester sees it in the same cycle its operands are latched.
    assign gnt         = (state_q == S_IDLE && win_found && !rst) ? (NREQ'(1) << winner) : '0;
    assign rsp_valid   = (state_q == S_DONE) ? (NREQ'(1) << ptr_q) : '0;
    assign rsp_product = prod_q;
    assign busy        = (state_q != S_IDLE);
    assign mul_start   = (state_q == S_START);
    assign mul_a       = a_q;
    assign mul_b       = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed scoreboard bench for mul_arbiter with an 8-cycle shift-add multiplier model.
// Expectations for the optional timeout path follow MUL_ARB_TIMEOUT_EN.
module tb_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    typedef struct {
        int          idx;
        logic [15:0] prod;
        logic        err;
        int          gcyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_product;
    logic        rsp_err;
    logic        busy;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_ready;
    logic [15:0] mul_product;

    mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_product (mul_product)
    );

    always #5 clk = ~clk;

    // Multiplier model: one partial product per cycle, ready 8 cycles after start; ready starts stale-high.
    logic        hold = 1'b0;
    logic        m_rdy_q = 1'b1;
    logic [15:0] m_prod_q = 16'hDEAD;
    logic [15:0] m_acc_q = 16'h0000;
    logic [7:0]  m_a_q = 8'h00;
    logic [7:0]  m_b_q = 8'h00;
    logic [3:0]  m_cnt_q = 4'd0;
    logic [2:0]  m_sh;
    logic [15:0] m_next;

    assign m_sh        = 3'(4'd8 - m_cnt_q);
    assign m_next      = m_acc_q + (m_b_q[m_sh] ? ({8'h00, m_a_q} << m_sh) : 16'h0000);
    assign mul_ready   = m_rdy_q & ~hold;
    assign mul_product = m_prod_q;

    always @(posedge clk) begin
        if (mul_start) begin
            m_a_q    <= mul_a;
            m_b_q    <= mul_b;
            m_acc_q  <= 16'h0000;
            m_cnt_q  <= 4'd8;
            m_rdy_q  <= 1'b0;
            m_prod_q <= 16'hDEAD;
        end else if (m_cnt_q != 4'd0) begin
            m_acc_q <= m_next;
            m_cnt_q <= m_cnt_q - 4'd1;
            if (m_cnt_q == 4'd1) begin
                m_rdy_q  <= 1'b1;
                m_prod_q <= m_next;
            end
        end
    end

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          last_gnt = -100;
    int          last_rsp = -100;
    int          rsp_cnt = 0;
    logic [15:0] last_prod = 16'h0000;
    logic        last_err = 1'b0;
    logic [7:0]  exp_a = 8'h00;
    logic [7:0]  exp_b = 8'h00;
    bit          tmo_mode = 1'b0;
    exp_t        exp_q[$];
    int          gnt_log[$];
    int          gnt_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    // Called at the falling edge: grants push expectations, responses pop and compare them.
    task automatic monitor();
        int   gi;
        exp_t e;
        cyc_n++;
        gi = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] === 1'b1 && gi < 0) gi = i;
        end
        if (gi >= 0) begin
            check("gnt_onehot", $countones(gnt), 1);
            check("gnt_while_idle", busy, 0);
            exp_a  = req_a[8*gi +: 8];
            exp_b  = req_b[8*gi +: 8];
            e.idx  = gi;
            e.gcyc = cyc_n;
            e.prod = 16'(exp_a) * 16'(exp_b);
            e.err  = 1'b0;
            e.lat  = 11;
            if (tmo_mode) begin
`ifdef MUL_ARB_TIMEOUT_EN
                e.prod = 16'h0000;
                e.err  = 1'b1;
                e.lat  = TIMEOUT + 2;
`else
                e.lat  = -1;
`endif
            end
            exp_q.push_back(e);
            gnt_log.push_back(gi);
            gnt_cyc.push_back(cyc_n);
            last_gnt = cyc_n;
        end
        if (mul_start === 1'b1) begin
            check("start_latency", cyc_n - last_gnt, 1);
            check("mul_a", mul_a, exp_a);
            check("mul_b", mul_b, exp_b);
            check("busy_in_start", busy, 1);
        end
        if (rsp_valid !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", rsp_valid, 32'(4'b0001 << e.idx));
                check("rsp_product", rsp_product, e.prod);
                check("rsp_err", rsp_err, e.err);
                check("busy_in_done", busy, 1);
                if (e.lat >= 0) check("rsp_latency", cyc_n - e.gcyc, e.lat);
            end
            last_prod = rsp_product;
            last_err  = rsp_err;
            rsp_cnt++;
            last_rsp  = cyc_n;
        end else if (cyc_n == last_rsp + 1) begin
            check("idle_after_done", busy, 0);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int max, input string tag);
        int k;
        k = 0;
        while (gnt_log.size() < n && k < max) begin
            cyc();
            k++;
        end
        if (gnt_log.size() < n) check(tag, gnt_log.size(), n);
    endtask

    task automatic wait_rsp(input int n, input int max, input string tag);
        int k;
        k = 0;
        while (rsp_cnt < n && k < max) begin
            cyc();
            k++;
        end
        if (rsp_cnt < n) check(tag, rsp_cnt, n);
    endtask

    task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] lit, input string tag);
        int g0;
        int r0;
        g0 = gnt_log.size();
        r0 = rsp_cnt;
        set_ops(idx, a, b);
        req = 4'(4'b0001 << idx);
        wait_grants(g0 + 1, 20, {tag, "_gnt_wait"});
        req = 4'b0000;
        wait_rsp(r0 + 1, 20, {tag, "_rsp_wait"});
        check({tag, "_idx"}, (gnt_log.size() > g0) ? gnt_log[g0] : -1, idx);
        check({tag, "_prod"}, last_prod, lit);
        check({tag, "_err"}, last_err, 0);
    endtask

    initial begin
        int base;
        int g0;
        int r0;

        rst   = 1'b1;
        req   = 4'b1111;
        req_a = 32'h0;
        req_b = 32'h0;
        set_ops(0, 8'd13, 8'd200);
        set_ops(1, 8'd23, 8'd183);
        set_ops(2, 8'd33, 8'd166);
        set_ops(3, 8'd43, 8'd149);
        repeat (2) @(posedge clk);
        #1;

        // Reset values, with every request already high.
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_product", rsp_product, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;

        // All four requesters from reset: 0,1,2,3,0 spaced 12 cycles apart.
        base = gnt_log.size();
        wait_grants(base + 5, 80, "rr4_gnt_wait");
        req = 4'b0000;
        wait_rsp(5, 30, "rr4_rsp_wait");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr4_order_%0d", i), (gnt_log.size() > base + i) ? gnt_log[base + i] : -1, i % 4);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr4_spacing_%0d", i),
                  (gnt_cyc.size() > base + i + 1) ? gnt_cyc[base + i + 1] - gnt_cyc[base + i] : -1, 12);
        end

        single(0, 8'd200, 8'd100, 16'h4E20, "single");

        // Requesters 1 and 3 held; requester 2 joins while 1 is being served.
        base = gnt_log.size();
        set_ops(1, 8'd17, 8'd19);
        set_ops(3, 8'd250, 8'd3);
        req = 4'b1010;
        wait_grants(base + 5, 70, "rr2_gnt_wait");
        set_ops(2, 8'd99, 8'd98);
        req[2] = 1'b1;
        wait_grants(base + 6, 20, "late_gnt_wait");
        req[2] = 1'b0;
        wait_grants(base + 7, 20, "rr2_last_wait");
        req = 4'b0000;
        wait_rsp(rsp_cnt + exp_q.size(), 30, "rr2_rsp_wait");
        begin
            int exp_order[7] = '{1, 3, 1, 3, 1, 2, 3};
            for (int i = 0; i < 7; i++) begin
                check($sformatf("rr2_order_%0d", i),
                      (gnt_log.size() > base + i) ? gnt_log[base + i] : -1, exp_order[i]);
            end
        end

        // Operand boundaries.
        single(3, 8'd255, 8'd255, 16'hFE01, "max_x_max");
        single(1, 8'd0, 8'h37, 16'h0000, "zero_x_37");
        single(2, 8'd1, 8'd255, 16'h00FF, "one_x_max");

        // Reset during the 5th BUSY cycle drops the operation.
        g0 = gnt_log.size();
        set_ops(1, 8'd77, 8'd3);
        req = 4'b0010;
        wait_grants(g0 + 1, 20, "rst_mid_gnt_wait");
        req = 4'b0000;
        repeat (5) cyc();
        check("rst_mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mul_start", mul_start, 0);
        check("rst_mid_mul_a", mul_a, 0);
        check("rst_mid_mul_b", mul_b, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_rsp_product", rsp_product, 0);
        r0 = rsp_cnt;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (15) cyc();
        check("rst_mid_no_rsp", rsp_cnt, r0);
        single(2, 8'd12, 8'd12, 16'h0090, "post_rst");

        // Multiplier never answers while hold is set.
        g0 = gnt_log.size();
        r0 = rsp_cnt;
        hold = 1'b1;
        tmo_mode = 1'b1;
        set_ops(3, 8'd7, 8'd9);
        req = 4'b1000;
        wait_grants(g0 + 1, 20, "tmo_gnt_wait");
        req = 4'b0000;
`ifdef MUL_ARB_TIMEOUT_EN
        wait_rsp(r0 + 1, TIMEOUT + 10, "tmo_rsp_wait");
        check("tmo_err", last_err, 1);
        check("tmo_prod", last_prod, 0);
        hold = 1'b0;
`else
        repeat (30) cyc();
        check("hold_busy", busy, 1);
        check("hold_no_rsp", rsp_cnt, r0);
        hold = 1'b0;
        wait_rsp(r0 + 1, 10, "hold_rsp_wait");
        check("hold_prod", last_prod, 16'd63);
        check("hold_err", last_err, 0);
`endif
        tmo_mode = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8x8 unsigned shift-add multiplier among NREQ requesters.
- Grants one requester at a time and latches its operands.
- Pulses the multiplier start, waits for its ready, then returns the 16-bit product to the granted requester with a one-cycle valid pulse.
- Sits between client blocks and the multiplier; this block is the only driver of the multiplier's start and operand inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, BUSY-cycle limit before an error response (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester request; held high with operands stable until gnt.
- req_a  input  NREQ*8  packed multiplicands; requester i uses bits [8i+7:8i].
- req_b  input  NREQ*8  packed multipliers; same packing as req_a.
- gnt  output  NREQ  one-hot grant, one cycle; operands are latched on that edge.
- rsp_valid  output  NREQ  one-hot response pulse, one cycle.
- rsp_product  output  16  product, valid while any rsp_valid bit is high.
- rsp_err  output  1  timeout flag, qualified by rsp_valid.
- busy  output  1  high in every state except IDLE.
- mul_start  output  1  start pulse to the multiplier.
- mul_a  output  8  multiplicand to the multiplier.
- mul_b  output  8  multiplier operand to the multiplier.
- mul_ready  input  1  multiplier done.
- mul_product  input  16  multiplier result.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - gnt, rsp_valid, rsp_err, busy and mul_start go to 0; mul_a, mul_b and rsp_product go to 0.
  - Round-robin pointer goes to NREQ-1, so requester 0 has first priority.
- States: IDLE -> START -> BUSY -> DONE -> IDLE.
- IDLE:
  - If req is nonzero, select the winner by searching from pointer+1 upward with wrap-around.
  - gnt[winner] = 1, combinational in IDLE only and gated by req.
  - On the edge: latch req_a/req_b of the winner into mul_a/mul_b, set pointer = winner, go to START.
  - If req is zero, gnt = 0 and the block stays in IDLE.
- START: mul_start = 1 for exactly this cycle; next state is BUSY.
- BUSY:
  - mul_ready is sampled only in BUSY and never in IDLE or START, because mul_ready is stale or unknown before the first start.
  - Stay in BUSY while mul_ready = 0.
  - When mul_ready = 1, capture mul_product into rsp_product and go to DONE.
- DONE: rsp_valid[pointer] = 1 for one cycle; next state is IDLE.
- Latency with the 8-cycle multiplier:
  - gnt in cycle t, mul_start in t+1, mul_ready first seen in t+10, rsp_valid in t+11.
  - Earliest next gnt is in t+12, so throughput is one operation per 12 cycles.
- mul_a and mul_b hold their values from the grant until the next grant.
- Requests:
  - A requester whose req is raised or dropped while the block is busy is simply considered again at the next IDLE; there is no queueing.
  - A requester that drops req before being granted is never granted.
  - A requester re-raising req in its own DONE cycle is eligible at the next IDLE, behind others per round-robin.
- Simultaneous requests: exactly one gnt bit is ever high; continuously asserted requesters are served in rotating order.
- Reset mid-operation:
  - The pending operation is dropped with no rsp_valid.
  - The external multiplier may keep counting; this is harmless because BUSY is only entered after this block issues a new start.
- Arithmetic: unsigned 8x8 to 16; this block does not modify the product.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with mul_ready still 0, go to DONE with rsp_err = 1 and rsp_product = 0.
  - rsp_valid is asserted normally.
  - If mul_ready = 1 in the same cycle the limit is hit, the product wins and rsp_err = 0.
- Not defined: no counter; BUSY waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single request: req[0] with A=200, B=100 -> gnt[0] in cycle t, mul_start in t+1, rsp_valid[0] in t+11 with rsp_product = 0x4E20, rsp_err = 0.
- All four requesters high from reset with distinct operands -> grants in order 0,1,2,3,0; each product correct; no gnt overlap; busy low only in IDLE cycles.
- Requesters 1 and 3 held high -> grants alternate 1,3,1,3; a late req[2] is served between 1 and 3 per pointer order.
- Boundaries: 255x255 -> 0xFE01; 0x37 -> 0x0000; 1x255 -> 0x00FF.
- Reset in the 5th BUSY cycle -> no rsp_valid for that requester; outputs return to reset values immediately; the next request 12x12 returns 0x0090.
- With MUL_ARB_TIMEOUT_EN and the bench holding mul_ready = 0 -> rsp_valid with rsp_err = 1 and rsp_product = 0 after TIMEOUT BUSY cycles; without the macro, busy stays high until mul_ready is released.
